// File: rtl/sub_pkg.sv
// Shared definitions for the subtractor family: byte width and sequencer state encoding.
package sub_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

endpackage

// File: rtl/sub8_slice.sv
// One byte of full subtraction: {bout,d} = a - b - bin, with bout taken from the 9th bit.
module sub8_slice
    import sub_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              bin,
    output logic [BYTE_W-1:0] d,
    output logic              bout
);

    logic [BYTE_W:0] res;

    assign res  = {1'b0, a} - {1'b0, b} - {{BYTE_W{1'b0}}, bin};
    assign d    = res[BYTE_W-1:0];
    assign bout = res[BYTE_W];

endmodule

// File: rtl/multibyte_sub_seq.sv
// Byte-serial wide subtractor: walks one shared sub8_slice across the operands LSB first,
// chaining the borrow, and hands the result out over a valid/ready interface.
module multibyte_sub_seq
    import sub_pkg::*;
#(
    parameter  int NBYTES = 2,
    localparam int W      = NBYTES * BYTE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         zero
);

    localparam int              IDXW = $clog2(NBYTES) + 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

    sub_state_t state, state_nxt;

    logic [W-1:0]      a_q, b_q, diff_q, diff_new;
    logic [IDXW-1:0]   idx;
    logic              borrow_q, bout_q, zero_q;
    logic              capture, step, last;
    logic [BYTE_W-1:0] slice_a, slice_b, slice_d;
    logic              slice_bo;

    assign last    = (idx == LAST);
    assign slice_a = a_q[int'(idx)*BYTE_W +: BYTE_W];
    assign slice_b = b_q[int'(idx)*BYTE_W +: BYTE_W];

    sub8_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (borrow_q),
        .d    (slice_d),
        .bout (slice_bo)
    );

    // zero must reflect the diff as it will be after the final byte lands
    always_comb begin
        diff_new = diff_q;
        diff_new[int'(idx)*BYTE_W +: BYTE_W] = slice_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // flush overrides every handshake, so it is decoded ahead of the state case
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end
                RUN: begin
                    step = 1'b1;
                    if (last) state_nxt = DONE;
                end
                DONE: if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx      <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else if (flush) begin
            idx      <= '0;
            borrow_q <= 1'b0;
        end else if (capture) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            idx      <= '0;
        end else if (step) begin
            diff_q   <= diff_new;
            borrow_q <= slice_bo;
            if (last) begin
                bout_q <= slice_bo;
                zero_q <= (diff_new == '0);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;

endmodule
